// File: rtl/xpb_reduce_sched.sv
// Time-shared xpb reduction-table lookup sequencer: LANES lookups per cycle, accumulated into one wide sum.
// Optional build macro XPB_SKIP_ZERO_EN suppresses ROM strobes for all-zero digit groups.
module xpb_reduce_sched #(
    parameter int NUM_DIGITS = 32,
    parameter int DIGIT_W    = 5,
    parameter int WORD_W     = 1024,
    parameter int LANES      = 4,
    parameter int ROM_LAT    = 1,
    localparam int IDX_W     = $clog2(NUM_DIGITS),
    localparam int GROUPS    = (NUM_DIGITS + LANES - 1) / LANES,
    localparam int ACC_W     = WORD_W + $clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] in_digits,
    output logic                          rom_req,
    output logic [LANES*IDX_W-1:0]        rom_idx,
    output logic [LANES*DIGIT_W-1:0]      rom_digit,
    input  logic [LANES*WORD_W-1:0]       rom_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_sum,
    output logic                          busy
);

    localparam int G_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                          state;
    logic [G_W-1:0]                  g;
    logic [NUM_DIGITS*DIGIT_W-1:0]   digits_q;
    logic [ROM_LAT-1:0]              slot_p;
    logic [ROM_LAT-1:0]              vld_p;
    logic                            accept;
    logic                            last_grp;
    logic [G_W-1:0]                  g_nxt;

    // Positions past the last digit drive idx=0 so the ROM sees a harmless address.
    function automatic logic [LANES*IDX_W-1:0] grp_idx(input logic [G_W-1:0] grp);
        int pos;
        grp_idx = '0;
        for (int l = 0; l < LANES; l++) begin
            pos = int'(grp) * LANES + l;
            if (pos < NUM_DIGITS)
                grp_idx[l*IDX_W +: IDX_W] = IDX_W'(pos);
        end
    endfunction

    function automatic logic [LANES*DIGIT_W-1:0] grp_dig(
        input logic [NUM_DIGITS*DIGIT_W-1:0] dig,
        input logic [G_W-1:0]                grp
    );
        int pos;
        grp_dig = '0;
        for (int l = 0; l < LANES; l++) begin
            pos = int'(grp) * LANES + l;
            if (pos < NUM_DIGITS)
                grp_dig[l*DIGIT_W +: DIGIT_W] = dig[pos*DIGIT_W +: DIGIT_W];
        end
    endfunction

    function automatic logic [ACC_W-1:0] lane_sum(input logic [LANES*WORD_W-1:0] d);
        lane_sum = '0;
        for (int l = 0; l < LANES; l++)
            lane_sum = lane_sum + ACC_W'(d[l*WORD_W +: WORD_W]);
    endfunction

    // Digit 0 always maps to a zero entry, so a skipped all-zero group leaves the sum unchanged.
    function automatic logic issue_en(input logic [LANES*DIGIT_W-1:0] dg);
`ifdef XPB_SKIP_ZERO_EN
        issue_en = |dg;
`else
        issue_en = 1'b1 | (^dg & 1'b0);
`endif
    endfunction

    assign accept    = (state == IDLE) && in_valid;
    assign last_grp  = (g == G_W'(GROUPS - 1));
    assign g_nxt     = g + 1'b1;
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    // Control: FSM, issue strobe, valid pipes and the accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            g       <= '0;
            rom_req <= 1'b0;
            slot_p  <= '0;
            vld_p   <= '0;
            out_sum <= '0;
        end else begin
            // slot_p times the drain even when strobes are skipped; vld_p gates accumulation.
            slot_p <= ROM_LAT'({slot_p, (state == ISSUE)});
            vld_p  <= ROM_LAT'({vld_p, rom_req});
            if (vld_p[ROM_LAT-1])
                out_sum <= out_sum + lane_sum(rom_data);
            case (state)
                IDLE: begin
                    if (accept) begin
                        g       <= '0;
                        out_sum <= '0;
                        rom_req <= issue_en(grp_dig(in_digits, '0));
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (last_grp) begin
                        rom_req <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        g       <= g_nxt;
                        rom_req <= issue_en(grp_dig(digits_q, g_nxt));
                    end
                end
                DRAIN: begin
                    if ((slot_p << 1) == '0)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data: operand latch and per-lane lookup address registers.
    always_ff @(posedge clk) begin
        if (accept) begin
            digits_q  <= in_digits;
            rom_idx   <= grp_idx('0);
            rom_digit <= grp_dig(in_digits, '0);
        end else if (state == ISSUE && !last_grp) begin
            rom_idx   <= grp_idx(g_nxt);
            rom_digit <= grp_dig(digits_q, g_nxt);
        end
    end

endmodule

// File: tb/tb_xpb_reduce_sched.sv
// Scoreboard bench for xpb_reduce_sched: ROM model f(p,d)=d*(p+1), one DUT at ROM_LAT=1 and one at ROM_LAT=3.
module tb_xpb_reduce_sched;

    localparam int ND    = 32;
    localparam int DW    = 5;
    localparam int WW    = 1024;
    localparam int LN    = 4;
    localparam int IW    = 5;
    localparam int ACC_W = WW + 5;
`ifdef XPB_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [ACC_W-1:0] sum;
        int               lat;
        int               rq_first;
        int               rq_last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nfail = 0;
    exp_t q0[$];
    exp_t q3[$];

    logic                 iv0 = 1'b0, ordy0 = 1'b1, ir0, rq0, ov0, busy0;
    logic [ND*DW-1:0]     dig0 = '0;
    logic [LN*IW-1:0]     ridx0;
    logic [LN*DW-1:0]     rdig0;
    logic [LN*WW-1:0]     rdata0;
    logic [ACC_W-1:0]     os0;

    logic                 iv3 = 1'b0, ordy3 = 1'b1, ir3, rq3, ov3, busy3;
    logic [ND*DW-1:0]     dig3 = '0;
    logic [LN*IW-1:0]     ridx3;
    logic [LN*DW-1:0]     rdig3;
    logic [LN*WW-1:0]     rdata3, r3a, r3b;
    logic [ACC_W-1:0]     os3;

    xpb_reduce_sched u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_digits(dig0),
        .rom_req(rq0), .rom_idx(ridx0), .rom_digit(rdig0), .rom_data(rdata0),
        .out_valid(ov0), .out_ready(ordy0), .out_sum(os0), .busy(busy0)
    );

    xpb_reduce_sched #(.ROM_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_digits(dig3),
        .rom_req(rq3), .rom_idx(ridx3), .rom_digit(rdig3), .rom_data(rdata3),
        .out_valid(ov3), .out_ready(ordy3), .out_sum(os3), .busy(busy3)
    );

    function automatic logic [LN*WW-1:0] rom_f(input logic [LN*IW-1:0] idx, input logic [LN*DW-1:0] dg);
        int p, d;
        rom_f = '0;
        for (int l = 0; l < LN; l++) begin
            p = int'(idx[l*IW +: IW]);
            d = int'(dg[l*DW +: DW]);
            rom_f[l*WW +: WW] = WW'(d * (p + 1));
        end
    endfunction

    // Unrequested slots return all-ones so any stray capture corrupts the sum.
    always @(posedge clk) rdata0 <= rq0 ? rom_f(ridx0, rdig0) : '1;
    always @(posedge clk) begin
        r3a    <= rq3 ? rom_f(ridx3, rdig3) : '1;
        r3b    <= r3a;
        rdata3 <= r3b;
    end

    task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act[63:0], exp[63:0]);
        end
    endtask

    int  acc_c[2], rq_first[2], rq_last[2];
    bit  seen[2];

    always @(negedge clk) begin
        logic ivk, irk, rqk, ovk;
        logic [ACC_W-1:0] osk;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            ivk = (k == 0) ? iv0 : iv3;
            irk = (k == 0) ? ir0 : ir3;
            rqk = (k == 0) ? rq0 : rq3;
            ovk = (k == 0) ? ov0 : ov3;
            osk = (k == 0) ? os0 : os3;
            if (rqk) begin
                if (rq_first[k] == 0) rq_first[k] = cyc - acc_c[k] + 1;
                rq_last[k] = cyc - acc_c[k] + 1;
            end
            if (ovk && !seen[k]) begin
                seen[k] = 1'b1;
                if ((k == 0 && q0.size() == 0) || (k == 1 && q3.size() == 0)) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_out dut%0d: got out_sum %0d, expected no output", k, osk[63:0]);
                end else begin
                    if (k == 0) e = q0.pop_front();
                    else        e = q3.pop_front();
                    chk($sformatf("out_sum dut%0d", k), osk, e.sum);
                    chk($sformatf("latency dut%0d", k), ACC_W'(cyc - acc_c[k] + 1), ACC_W'(e.lat));
                    chk($sformatf("rom_req_first dut%0d", k), ACC_W'(rq_first[k]), ACC_W'(e.rq_first));
                    chk($sformatf("rom_req_last dut%0d", k), ACC_W'(rq_last[k]), ACC_W'(e.rq_last));
                end
            end
            if (ivk && irk && rst_n) begin
                acc_c[k]    = cyc + 1;
                rq_first[k] = 0;
                rq_last[k]  = 0;
                seen[k]     = 1'b0;
            end
        end
    end

    task automatic wait_hs(input int k);
        int t = 0;
        while (!((k == 0) ? (ov0 && ordy0) : (ov3 && ordy3)) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            nvec++;
            nfail++;
            $display("FAIL timeout dut%0d: got no handshake, expected out_valid within 200 cycles", k);
        end
        @(negedge clk);
    endtask

    task automatic send(input int k, input logic [ND*DW-1:0] d, input logic [ACC_W-1:0] s,
                        input int lat, input int f, input int l, input bit wait_done);
        exp_t e;
        e.sum = s; e.lat = lat; e.rq_first = f; e.rq_last = l;
        if (k == 0) q0.push_back(e); else q3.push_back(e);
        @(negedge clk);
        if (k == 0) begin iv0 = 1'b1; dig0 = d; end
        else        begin iv3 = 1'b1; dig3 = d; end
        @(negedge clk);
        iv0 = 1'b0;
        iv3 = 1'b0;
        if (wait_done) wait_hs(k);
    endtask

    initial begin
        logic [ND*DW-1:0] v;
        int bad;
        repeat (3) @(negedge clk);
        chk("rst in_ready", ACC_W'(ir0), 1);
        chk("rst out_valid", ACC_W'(ov0), 0);
        chk("rst busy", ACC_W'(busy0), 0);
        chk("rst rom_req", ACC_W'(rq0), 0);
        chk("rst out_sum", os0, 0);
        chk("rst out_sum lat3", os3, 0);
        chk("rst busy lat3", ACC_W'(busy3), 0);
        rst_n = 1'b1;

        send(0, '0, 0, 10, SKIP ? 0 : 1, SKIP ? 0 : 8, 1'b1);
        v = '0; v[5*DW +: DW] = 5'd1;
        send(0, v, 6, 10, SKIP ? 2 : 1, SKIP ? 2 : 8, 1'b1);
        send(0, '1, 16368, 10, 1, 8, 1'b1);

        // Back-pressure: hold out_ready low for 20 cycles.
        ordy0 = 1'b0;
        v = '0; v[0 +: DW] = 5'd3;
        send(0, v, 3, 10, 1, SKIP ? 1 : 8, 1'b0);
        for (int t = 0; t < 200 && !ov0; t++) @(negedge clk);
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            if (os0 !== ACC_W'(3) || ir0 !== 1'b0 || ov0 !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("bp hold stable", ACC_W'(bad), 0);
        ordy0 = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", ACC_W'(ir0), 1);
        chk("bp release out_valid", ACC_W'(ov0), 0);

        // Reset in the 4th ISSUE cycle of an all-31 operand.
        @(negedge clk);
        iv0 = 1'b1; dig0 = '1;
        @(negedge clk);
        iv0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid busy before rst", ACC_W'(busy0), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid rst in_ready", ACC_W'(ir0), 1);
        chk("mid rst out_valid", ACC_W'(ov0), 0);
        chk("mid rst rom_req", ACC_W'(rq0), 0);
        rst_n = 1'b1;
        v = '0; v[0 +: DW] = 5'd2;
        send(0, v, 2, 10, 1, SKIP ? 1 : 8, 1'b1);

        v = '0; v[31*DW +: DW] = 5'd1;
        send(1, v, 32, 12, SKIP ? 8 : 1, 8, 1'b1);
        send(1, '1, 16368, 12, 1, 8, 1'b1);
        send(1, '0, 0, 12, SKIP ? 0 : 1, SKIP ? 0 : 8, 1'b1);

        repeat (5) @(negedge clk);
        if (q0.size() != 0 || q3.size() != 0) begin
            nvec++;
            nfail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q0.size() + q3.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
